// File: rtl/rr_arbiter8_pkg.sv
// Shared constants and state encoding for the 8-way round-robin arbiter.
package rr_arbiter8_pkg;

    localparam int unsigned NUM_REQ = 8;
    localparam int unsigned IDX_W   = 3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StGap  = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter8_dec.sv
// 3-to-8 decoder: turns a requester index into a one-hot lane enable.
module rr_arbiter8_dec
    import rr_arbiter8_pkg::*;
(
    input  logic [IDX_W-1:0]   idx,
    output logic [NUM_REQ-1:0] onehot
);

    // Exactly one output bit set for every index value.
    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for one resource shared by 8 requesters. Registered one-hot
// grant, one idle cycle between owners, optional hold timeout against starvation.
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] req_mask,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_id,
    output logic               gnt_valid,
    output logic               timeout_pulse
);

    localparam bit              TimeoutEn = (MAX_HOLD != 0);
    localparam int unsigned     HoldLimI  = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
    localparam logic [CNT_W-1:0] HoldLim  = HoldLimI[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CntMax   = '1;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     id_q, id_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic                 valid_q, valid_d;
    logic                 tpulse_q, tpulse_d;

    logic [NUM_REQ-1:0]   elig;
    logic [NUM_REQ-1:0]   others;
    logic [IDX_W-1:0]     next_id;
    logic [NUM_REQ-1:0]   next_onehot;

    // First set bit of e searching upward from p, wrapping 7 -> 0.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] e,
                                                 input logic [IDX_W-1:0]   p);
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] win;
        win = p;
        // Walk from the far end so the nearest hit to p is assigned last.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = p + IDX_W'(i);
            if (e[idx]) begin
                win = idx;
            end
        end
        return win;
    endfunction

    // Eligible requesters, and those competing with the current owner.
    always_comb begin
        elig        = req & req_mask;
        others      = elig;
        others[id_q] = 1'b0;
        next_id     = rr_pick(elig, ptr_q);
    end

    rr_arbiter8_dec u_dec (
        .idx    (next_id),
        .onehot (next_onehot)
    );

    // Next-state logic: grant from IDLE, release/preempt from BUSY, one GAP cycle.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        id_d     = id_q;
        gnt_d    = gnt_q;
        valid_d  = valid_q;
        tpulse_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (|elig) begin
                    state_d = StBusy;
                    id_d    = next_id;
                    gnt_d   = next_onehot;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            StBusy: begin
                if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // Release takes priority, so a same-cycle timeout never pulses.
                if (!req[id_q]) begin
                    state_d = StGap;
                    ptr_d   = id_q + 1'b1;
                    gnt_d   = '0;
                    valid_d = 1'b0;
                end else if (TimeoutEn && (cnt_q >= HoldLim) && (|others)) begin
                    state_d  = StGap;
                    ptr_d    = id_q + 1'b1;
                    gnt_d    = '0;
                    valid_d  = 1'b0;
                    tpulse_d = 1'b1;
                end
            end
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            cnt_q    <= '0;
            id_q     <= '0;
            gnt_q    <= '0;
            valid_q  <= 1'b0;
            tpulse_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            id_q     <= id_d;
            gnt_q    <= gnt_d;
            valid_q  <= valid_d;
            tpulse_q <= tpulse_d;
        end
    end

    assign gnt           = gnt_q;
    assign gnt_id        = id_q;
    assign gnt_valid     = valid_q;
    assign timeout_pulse = tpulse_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios plus random traffic,
// every cycle compared against an owner/pointer reference model.
module tb_rr_arbiter8;

    localparam int unsigned MaxHold = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] req_mask;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: current owner (-1 = none), gap flag, pointer, cycles owned.
    int m_owner;
    int m_ptr;
    int m_held;
    bit m_gap;
    bit m_pulse;

    always #5 clk = ~clk;

    rr_arbiter8 #(
        .MAX_HOLD (MaxHold),
        .CNT_W    (5)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .req_mask      (req_mask),
        .gnt           (gnt),
        .gnt_id        (gnt_id),
        .gnt_valid     (gnt_valid),
        .timeout_pulse (timeout_pulse)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_held  = 0;
        m_gap   = 0;
        m_pulse = 0;
    endtask

    // One clock edge of the arbitration rules, using the inputs seen at that edge.
    task automatic model_step();
        logic [7:0] elig;
        logic [7:0] others;
        elig    = req & req_mask;
        m_pulse = 0;
        if (m_owner >= 0) begin
            others = elig & ~(8'd1 << m_owner);
            if (!req[m_owner]) begin
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
                m_gap   = 1;
            end else if (MaxHold != 0 && m_held >= int'(MaxHold) && others != 8'd0) begin
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
                m_gap   = 1;
                m_pulse = 1;
            end else begin
                m_held++;
            end
        end else if (m_gap) begin
            m_gap = 0;
        end else if (elig != 8'd0) begin
            for (int k = 0; k < 8; k++) begin
                if (elig[(m_ptr + k) % 8]) begin
                    m_owner = (m_ptr + k) % 8;
                    m_held  = 1;
                    break;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [7:0] exp_gnt;
        exp_gnt = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
        check_eq("gnt", gnt, exp_gnt);
        check_eq("gnt_valid", gnt_valid, (m_owner >= 0) ? 1 : 0);
        check_eq("timeout_pulse", timeout_pulse, m_pulse);
        check_eq("gnt_onehot0", $onehot0(gnt), 1);
        if (m_owner >= 0) begin
            check_eq("gnt_id", gnt_id, m_owner);
        end
    endtask

    // Advance one clock: model at the edge, compare on the falling edge.
    task automatic cycle(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            compare_all();
        end
    endtask

    // Returns on the first falling edge where a grant is visible, bounded.
    task automatic wait_grant();
        for (int i = 0; i < 10; i++) begin
            if (gnt_valid) break;
            cycle();
        end
        check_eq("wait_gnt", gnt_valid, 1);
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        req      = 8'h00;
        req_mask = 8'hFF;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_gnt", gnt, 8'h00);
        check_eq("rst_gnt_id", gnt_id, 3'd0);
        check_eq("rst_gnt_valid", gnt_valid, 1'b0);
        check_eq("rst_timeout", timeout_pulse, 1'b0);
        rst_n = 1'b1;
    endtask

    // Reset asserted between edges must clear outputs without waiting for a clock.
    task automatic async_reset_check();
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_gnt", gnt, 8'h00);
        check_eq("async_gnt_valid", gnt_valid, 1'b0);
        check_eq("async_gnt_id", gnt_id, 3'd0);
        check_eq("async_timeout", timeout_pulse, 1'b0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int pulses;
        int exp_id;

        model_reset();
        apply_reset();

        // 1: single requester, release, gap.
        req = 8'h01;
        cycle();
        check_eq("t1_gnt", gnt, 8'h01);
        req = 8'h00;
        cycle(3);

        // 2: fairness between 0 and 7 from a fresh pointer.
        apply_reset();
        req    = 8'h81;
        exp_id = 0;
        for (int r = 0; r < 4; r++) begin
            wait_grant();
            check_eq("t2_fair_id", gnt_id, exp_id);
            cycle(2);
            req = 8'h81 & ~gnt;
            cycle();
            req    = 8'h81;
            exp_id = (exp_id == 0) ? 7 : 0;
        end
        req = 8'h00;
        cycle(3);

        // 3: timeout preempts owner 2 in favour of waiting requester 5.
        apply_reset();
        req = 8'h04;
        wait_grant();
        req    = 8'h24;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (timeout_pulse) pulses++;
            if (gnt == 8'h20) break;
        end
        check_eq("t3_pulses", pulses, 1);
        check_eq("t3_gnt", gnt, 8'h20);
        req = 8'h00;
        cycle(3);

        // 4: lone owner holds well past the limit with no preemption.
        req = 8'h08;
        wait_grant();
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (timeout_pulse) pulses++;
        end
        check_eq("t4_pulses", pulses, 0);
        check_eq("t4_gnt", gnt, 8'h08);
        req = 8'h00;
        cycle(3);

        // 5a: mask steers the first grant to requester 4.
        req_mask = 8'hF0;
        req      = 8'hFF;
        wait_grant();
        check_eq("t5_mask_id", gnt_id, 3'd4);
        // 5b: owner drops req in the cycle its timeout would fire.
        cycle(3);
        req = 8'hEF;
        cycle();
        check_eq("t5_no_pulse", timeout_pulse, 1'b0);
        check_eq("t5_released", gnt_valid, 1'b0);
        req      = 8'h00;
        req_mask = 8'hFF;
        cycle(3);

        // 6: async reset mid-grant, then pointer back at 0.
        req = 8'h24;
        wait_grant();
        cycle(2);
        async_reset_check();
        req = 8'h40;
        wait_grant();
        check_eq("t6_gnt_id", gnt_id, 3'd6);
        req = 8'h41;
        cycle(2);
        req = 8'h01;
        cycle(4);
        req = 8'h00;
        cycle(3);

        // Random traffic: sticky requests, occasional mask changes and resets.
        req      = 8'h00;
        req_mask = 8'hFF;
        for (int i = 0; i < 800; i++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
            end
            if ($urandom_range(0, 19) == 0) begin
                req_mask = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
            end
            if ($urandom_range(0, 199) == 0) begin
                async_reset_check();
            end else begin
                cycle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one 8-way resource between 8 requesters.
- Produces a registered one-hot grant by decoding a 3-bit winner index.
- Enforces a one-cycle turnaround gap between owners.
- Supports an optional hold-timeout so one owner cannot starve the others.
- Sits in front of the decoder-selected datapath; its one-hot grant drives the per-lane enables.

Parameters:
- MAX_HOLD, 16, cycles an owner may hold the grant while another requester waits; 0 disables the timeout.
- CNT_W, 5, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  8  request per requester; the owner keeps it high for as long as it uses the resource.
- req_mask  in  8  1 = requester eligible; a masked request is ignored for arbitration only.
- gnt  out  8  one-hot grant; all zero when the resource is free.
- gnt_id  out  3  index of the current owner; valid only while gnt_valid is high.
- gnt_valid  out  1  high while any grant is held.
- timeout_pulse  out  1  single-cycle pulse when the owner is preempted.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-grant):
  - gnt = 0, gnt_id = 0, gnt_valid = 0, timeout_pulse = 0.
  - Priority pointer ptr = 0, hold counter = 0, state = IDLE.
- Eligible set: elig = req & req_mask.
- State machine, three states: IDLE, BUSY, GAP. All outputs are registered.
- IDLE:
  - If elig is nonzero, the winner is the first set bit searching upward from ptr, wrapping 7 -> 0.
  - Register gnt_id = winner, gnt = decode(winner), gnt_valid = 1, clear the hold counter, go to BUSY.
  - Latency: elig seen at edge N, gnt visible after edge N (one cycle).
  - If elig is zero, stay in IDLE with outputs at zero.
- BUSY:
  - Hold counter increments each cycle and saturates at 2^CNT_W - 1.
  - Release: if req[gnt_id] == 0, then ptr = gnt_id + 1 (mod 8), clear the grant, go to GAP.
  - Timeout: if MAX_HOLD != 0, counter >= MAX_HOLD - 1, req[gnt_id] == 1, and elig has any bit set other than gnt_id:
    - ptr = gnt_id + 1 (mod 8), clear the grant, timeout_pulse = 1 for one cycle, go to GAP.
  - If no other eligible requester is waiting, the owner keeps the grant indefinitely and the counter saturates.
  - Masking the current owner mid-grant does not revoke the grant; only dropping req releases it.
- GAP:
  - Exactly one cycle with gnt = 0 and gnt_valid = 0, then go to IDLE.
  - Minimum re-grant latency after a release is therefore 2 cycles.
- Release and timeout in the same cycle: release wins and timeout_pulse stays 0.
- Invariant: at most one bit of gnt is ever set; gnt == decode(gnt_id) whenever gnt_valid is high.
- ptr wrap: owner 7 releases -> ptr = 0.
- Requests that change while in GAP are sampled in IDLE on the next cycle.

Decomposition:
- Shared package/header holds:
  - State encodings: IDLE = 2'd0, BUSY = 2'd1, GAP = 2'd2.
  - NUM_REQ = 8 and IDX_W = 3 constants.
- One sub-module: the existing Decoder3to8, instanced to turn next_id into the one-hot value that is then registered into gnt.
- The rotate-and-priority-search is a combinational function inside rr_arbiter8, not a separate module.

Test Plan:
1. Reset then req = 8'h01, mask = 8'hFF -> after one edge gnt = 8'h01, gnt_id = 0, gnt_valid = 1; drop req[0] -> gnt = 0 for the GAP cycle, then IDLE.
2. Fairness: req = 8'h81 held; each owner drops req for one cycle after 3 cycles of ownership -> grants alternate 0, 7, 0, 7 and ptr wraps 7 -> 0 between grants.
3. Timeout, MAX_HOLD = 4: requester 2 holds req, requester 5 asserts -> after 4 BUSY cycles timeout_pulse = 1 for one cycle, one GAP cycle, then gnt = 8'h20.
4. No contention, MAX_HOLD = 4: requester 3 holds for 40 cycles alone -> grant stays 8'h08, counter saturates, no timeout_pulse.
5. Mask and same-cycle events:
   - req = 8'hFF, mask = 8'hF0 -> first grant goes to requester 4.
   - Owner releases in the same cycle the timeout would fire -> no timeout_pulse.
6. Async reset: assert rst_n low mid-BUSY between clock edges -> gnt, gnt_valid and gnt_id clear immediately; after release, req = 8'h40 -> grant to 6 (ptr back at 0).
